fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 161 ++++++++++++++++
 tb/tb_fetch_unit.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end.
//   Issues one instruction read at a time to imem, buffers fetched words in
//   a 2-entry FIFO of {pc, instr, fault} and presents the head to decode.
//   Drives the PC register input (next_pc) combinationally.
// Ports:
//   clk, reset                 - clock, async active-low reset
//   current_pc / next_pc       - PC register output / input
//   imem_req, imem_addr        - registered read request and address
//   imem_ack, imem_rdata       - read completion and data
//   redirect_valid/redirect_pc - branch/jump: flush buffer, load new PC
//   out_valid/pc/instr/fault   - head of fetch buffer
//   out_ready                  - decode accepts head this cycle
module fetch_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] current_pc,
  output logic [31:0] next_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_fault,
  input  logic        out_ready
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_FAULT = 2'd3;

  logic [1:0]       state, state_nxt;
  logic [1:0]       count;
  logic             rd_ptr, wr_ptr;
  logic [1:0][31:0] fifo_pc;
  logic [1:0][31:0] fifo_instr;
  logic [1:0]       fifo_fault;
  logic [7:0]       timer;

  logic             pop, push, push_fault, issue, tmo, aligned, busy;
  logic [31:0]      push_pc, push_instr;
  logic [2:0]       count_after;

  assign aligned     = (current_pc[1:0] == 2'b00);
  assign out_valid   = (count != 2'd0);
  assign pop         = out_valid & out_ready & ~redirect_valid;
  // timer holds the number of already-elapsed REQ/DRAIN cycles without ack,
  // so this is the TIMEOUT-th such cycle
  assign tmo         = (timer == 8'(TIMEOUT - 1));
  assign busy        = (state == S_REQ) || (state == S_DRAIN);
  // occupancy after this cycle's ack push, used for back-to-back issue
  assign count_after = {1'b0, count} + 3'd1 - {2'b00, pop};

  assign out_pc    = out_valid ? fifo_pc[rd_ptr]    : 32'h0;
  assign out_instr = out_valid ? fifo_instr[rd_ptr] : 32'h0;
  assign out_fault = out_valid ? fifo_fault[rd_ptr] : 1'b0;

  always_comb begin
    state_nxt  = state;
    issue      = 1'b0;
    push       = 1'b0;
    push_pc    = imem_addr;
    push_instr = 32'h0;
    push_fault = 1'b0;
    case (state)
      S_IDLE: begin
        if (!redirect_valid && count < 2'd2) begin
          if (aligned) begin
            issue     = 1'b1;
            state_nxt = S_REQ;
          end else begin
            push       = 1'b1;
            push_pc    = current_pc;
            push_fault = 1'b1;
            state_nxt  = S_FAULT;
          end
        end
      end
      S_REQ: begin
        if (redirect_valid) begin
          // outstanding read must still complete; its data is dropped
          if (imem_ack || tmo) state_nxt = S_IDLE;
          else                 state_nxt = S_DRAIN;
        end else if (imem_ack) begin
          push       = 1'b1;
          push_instr = imem_rdata;
          if (count_after < 3'd2 && aligned) begin
            issue     = 1'b1;
            state_nxt = S_REQ;
          end else begin
            state_nxt = S_IDLE;
          end
        end else if (tmo) begin
          push       = 1'b1;
          push_fault = 1'b1;
          state_nxt  = S_FAULT;
        end
      end
      S_DRAIN: begin
        if (imem_ack || tmo) state_nxt = S_IDLE;
      end
      default: begin
        if (redirect_valid) state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    next_pc = current_pc;
    if (!reset)              next_pc = 32'h0;
    else if (redirect_valid) next_pc = redirect_pc;
    else if (issue)          next_pc = current_pc + 32'd4;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      imem_req  <= 1'b0;
      imem_addr <= 32'h0;
      timer     <= 8'h0;
    end else begin
      state    <= state_nxt;
      imem_req <= (state_nxt == S_REQ) || (state_nxt == S_DRAIN);
      if (issue) imem_addr <= current_pc;
      if (issue || !busy || imem_ack) timer <= 8'h0;
      else                            timer <= timer + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else if (redirect_valid) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      count <= count + 2'(push) - 2'(pop);
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
    end
  end

  // storage needs no reset: outputs are masked while the buffer is empty
  always_ff @(posedge clk) begin
    if (push && !redirect_valid) begin
      fifo_pc[wr_ptr]    <= push_pc;
      fifo_instr[wr_ptr] <= push_instr;
      fifo_fault[wr_ptr] <= push_fault;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus randomized traffic for fetch_unit.
// A PC register and memory model live in the bench; a stream scoreboard
// predicts every entry decode accepts from the program-flow rule
// (target, target+4, ... after each redirect; misaligned -> fault entry).
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic [31:0] out_pc, out_instr;
  logic        out_fault;
  logic        out_ready = 1'b0;

  int n_chk = 0;
  int n_err = 0;
  int pops  = 0;

  // memory / scoreboard controls
  bit ack_en = 1'b1;
  int max_wait = 0;
  int wait_left = 0;
  bit spur_en = 1'b0;
  bit proto_en = 1'b1;

  fetch_unit #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .current_pc(pc), .next_pc(next_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .out_valid(out_valid), .out_pc(out_pc),
    .out_instr(out_instr), .out_fault(out_fault), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset)
    if (!reset) pc <= 32'h0;
    else        pc <= next_pc;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // memory: answers requests after a random wait, may ack spuriously when idle
  always @(negedge clk) begin
    if (imem_req && ack_en && wait_left == 0) begin
      imem_ack   = 1'b1;
      imem_rdata = memfn(imem_addr);
      wait_left  = (max_wait == 0) ? 0 : int'($urandom_range(0, max_wait));
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      if (imem_req && wait_left > 0) wait_left--;
      if (!imem_req && spur_en && $urandom_range(0, 7) == 0) imem_ack = 1'b1;
    end
  end

  // stream scoreboard and request-stability check
  logic [31:0] exp_pc = 32'h0;
  bit          fault_seen = 1'b0;
  bit          prev_req = 1'b0, prev_ack = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  always @(negedge clk) begin
    #2;
    if (!reset) begin
      exp_pc = 32'h0; fault_seen = 1'b0; prev_req = 1'b0;
    end else begin
      if (proto_en && prev_req && !prev_ack) begin
        chk("req_hold", 32'(imem_req), 32'd1);
        chk("addr_hold", imem_addr, prev_addr);
      end
      if (out_valid && out_ready && !redirect_valid) begin
        pops++;
        chk("pop_after_fault", 32'(fault_seen), 32'd0);
        chk("sb_pc", out_pc, exp_pc);
        if (exp_pc[1:0] != 2'b00) begin
          chk("sb_instr", out_instr, 32'h0);
          chk("sb_fault", 32'(out_fault), 32'd1);
          fault_seen = 1'b1;
        end else begin
          chk("sb_instr", out_instr, memfn(exp_pc));
          chk("sb_fault", 32'(out_fault), 32'd0);
        end
        exp_pc = exp_pc + 32'd4;
      end
      if (redirect_valid) begin
        chk("redir_npc", next_pc, redirect_pc);
        exp_pc = redirect_pc;
        fault_seen = 1'b0;
      end
      prev_req = imem_req; prev_ack = imem_ack; prev_addr = imem_addr;
    end
  end

  task automatic do_reset(input bit en, input bit rdy);
    reset = 1'b0;
    redirect_valid = 1'b0;
    out_ready = rdy;
    ack_en = en;
    wait_left = 0;
    step(); step();
    reset = 1'b1;
  endtask

  task automatic redirect(input logic [31:0] t);
    redirect_valid = 1'b1;
    redirect_pc = t;
    step();
    redirect_valid = 1'b0;
  endtask

  logic [31:0] rpc;

  initial begin
    #2 reset = 1'b0;
    step();
    // reset state
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_instr", out_instr, 32'h0);
    chk("rst_fault", 32'(out_fault), 32'd0);
    chk("rst_npc", next_pc, 32'h0);

    // zero-wait streaming, decode always ready
    do_reset(1'b1, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k <= 3) begin
        chk("stream_req", 32'(imem_req), 32'd1);
        chk("stream_addr", imem_addr, 32'(4 * (k - 1)));
      end
      if (k >= 2) begin
        chk("stream_valid", 32'(out_valid), 32'd1);
        chk("stream_pc", out_pc, 32'(4 * (k - 2)));
        chk("stream_instr", out_instr, memfn(32'(4 * (k - 2))));
        chk("stream_fault", 32'(out_fault), 32'd0);
      end
    end

    // backpressure: two entries then hold at 0x08
    do_reset(1'b1, 1'b0);
    step(); step(); step();
    chk("bp_req", 32'(imem_req), 32'd0);
    chk("bp_npc", next_pc, 32'h8);
    chk("bp_pc", pc, 32'h8);
    step(); step(); step();
    chk("bp_hold_req", 32'(imem_req), 32'd0);
    chk("bp_hold_npc", next_pc, 32'h8);
    out_ready = 1'b1;
    for (int i = 0; i < 20 && !imem_req; i++) step();
    chk("bp_resume_addr", imem_addr, 32'h8);
    for (int i = 0; i < 6; i++) step();

    // redirect while a read is outstanding
    do_reset(1'b1, 1'b1);
    step(); step();
    chk("rd_addr4", imem_addr, 32'h4);
    ack_en = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'hA0;
    step();
    redirect_valid = 1'b0;
    chk("rd_flush_valid", 32'(out_valid), 32'd0);
    chk("rd_drain_req", 32'(imem_req), 32'd1);
    step(); step(); step();
    chk("rd_drain_addr", imem_addr, 32'h4);
    ack_en = 1'b1;
    step();
    chk("rd_discard_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 20 && !imem_req; i++) step();
    chk("rd_new_addr", imem_addr, 32'hA0);
    for (int i = 0; i < 20 && !out_valid; i++) step();
    chk("rd_new_pc", out_pc, 32'hA0);

    // misaligned redirect, then recovery
    out_ready = 1'b0;
    redirect(32'h102);
    for (int i = 0; i < 20 && !out_valid; i++) step();
    chk("mis_pc", out_pc, 32'h102);
    chk("mis_instr", out_instr, 32'h0);
    chk("mis_fault", 32'(out_fault), 32'd1);
    step(); step(); step();
    chk("mis_req", 32'(imem_req), 32'd0);
    chk("mis_npc", next_pc, 32'h102);
    out_ready = 1'b1;
    redirect(32'h100);
    for (int i = 0; i < 20 && !imem_req; i++) step();
    chk("rec_addr", imem_addr, 32'h100);
    for (int i = 0; i < 20 && !out_valid; i++) step();
    chk("rec_pc", out_pc, 32'h100);
    chk("rec_fault", 32'(out_fault), 32'd0);

    // timeout: memory never answers
    proto_en = 1'b0;
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 16; i++) step();
    chk("to_req_pre", 32'(imem_req), 32'd1);
    chk("to_valid_pre", 32'(out_valid), 32'd0);
    step();
    chk("to_req", 32'(imem_req), 32'd0);
    chk("to_valid", 32'(out_valid), 32'd1);
    chk("to_pc", out_pc, 32'h0);
    chk("to_instr", out_instr, 32'h0);
    chk("to_fault", 32'(out_fault), 32'd1);
    step(); step(); step(); step();
    chk("to_hold_req", 32'(imem_req), 32'd0);
    chk("to_hold_npc", next_pc, 32'h4);
    proto_en = 1'b1;

    // asynchronous reset in the middle of a request
    do_reset(1'b1, 1'b0);
    step(); step();
    chk("ar_pre_req", 32'(imem_req), 32'd1);
    chk("ar_pre_valid", 32'(out_valid), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("ar_req", 32'(imem_req), 32'd0);
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_npc", next_pc, 32'h0);
    step();

    // randomized traffic
    do_reset(1'b1, 1'b1);
    max_wait = 3;
    spur_en = 1'b1;
    pops = 0;
    for (int c = 0; c < 4000; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      rpc = $urandom & 32'h0000_3FFC;
      if ($urandom_range(0, 4) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
      redirect_pc = rpc;
      step();
    end
    redirect_valid = 1'b0;
    chk("rand_progress", 32'(pops > 300), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
